phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Multi-cycle phase generator for the processor core.
- Drives the 3-bit `phase` bus consumed by the combinational control decoder.
- Handles the run/stop start key (`exec`), HLT detection, memory-wait stalls, a stall watchdog and a retired-instruction counter.
- Sits beside the control decoder; all datapath enables remain decoder outputs.

Parameters:
- PHASE_MAX, 5: last phase of an instruction; legal 4..7; phases run 1..PHASE_MAX.
- MEM_PHASE, 4: second phase that honours mem_wait (phase 1 always does); legal 2..PHASE_MAX.
- WAIT_MAX, 255: maximum consecutive stalled cycles before timeout; legal 1..65535.
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- exec  input  1  run/stop key level; internally rising-edge detected
- hlt  input  1  high when the current IR holds HLT (op=11, alu_op=1111)
- mem_wait  input  1  memory not ready; stalls phase 1 and MEM_PHASE
- phase  output  3  current phase; 0 = not executing
- running  output  1  high in any phase 1..PHASE_MAX
- halted  output  1  high in HALT state
- timeout  output  1  sticky; set by watchdog expiry
- p1_start  output  1  one-cycle pulse in the first cycle of each phase 1
- retired  output  CNT_W  instructions completed, wraps modulo 2^CNT_W

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Edge detect:
  - exec_rise = exec & ~exec_q, where exec_q is registered exec.
  - On rst, exec_q loads the current exec, so a key held through reset does not start the core.
- State machine: IDLE, RUN (phase register 1..PHASE_MAX), HALT.
- Reset (takes precedence over everything, mid-instruction included):
  - state=IDLE, phase=0, running=0, halted=0, timeout=0, p1_start=0, retired=0.
  - stop_pending=0, wait_cnt=0.
- IDLE:
  - exec_rise -> phase=1, p1_start=1 next cycle.
  - Otherwise hold.
- RUN, stall = mem_wait & (phase==1 | phase==MEM_PHASE):
  - While stalled, phase holds and wait_cnt increments.
  - When not stalled, wait_cnt clears.
- Watchdog:
  - If stall is still true when wait_cnt==WAIT_MAX-1, next cycle state=HALT, phase=0, timeout=1.
  - retired is not incremented.
  - Timeout takes precedence over exec_rise in the same cycle.
- RUN, not stalled:
  - phase==2 and hlt=1: go HALT (phase=0, halted=1), retired+1. HLT is checked only in phase 2.
  - phase<PHASE_MAX otherwise: phase+1.
  - phase==PHASE_MAX: retired+1. If stop_pending or a simultaneous exec_rise, go IDLE and clear stop_pending. Otherwise phase=1 with p1_start=1.
- RUN, exec_rise at any phase below PHASE_MAX sets stop_pending. The instruction always completes; no mid-instruction abort except rst.
- HALT:
  - exec_rise -> phase=1, halted=0, timeout=0, p1_start=1, stop_pending=0.
  - Otherwise hold.
- p1_start is asserted exactly once per phase-1 entry, and not again during phase-1 stall cycles.
- retired increments by at most 1 per cycle and wraps from all-ones to 0 without a flag.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - Adds input port `step_mode` (1 bit), placed after mem_wait.
  - When step_mode=1 at the PHASE_MAX exit, the sequencer goes to IDLE regardless of stop_pending, so each exec_rise executes exactly one instruction.
  - HLT and timeout behaviour are unchanged.
- Undefined:
  - Port absent; behaves as step_mode=0.

Test Plan:
- Default parameters, mem_wait=0, hlt=0: rst, then exec pulse -> phase sequence 1,2,3,4,5,1,... one per cycle. p1_start high in each phase-1 cycle. retired=3 after 15 run cycles.
- Second exec pulse while phase=3 -> phases 4,5 complete, then phase=0, running=0, retired incremented once more. A third pulse restarts at phase 1.
- hlt=1 during phase 2 -> next cycle phase=0, halted=1, retired+1. exec pulse -> phase=1, halted=0.
- mem_wait=1 for 3 cycles entering phase 4 -> phase holds at 4 for 3 extra cycles, then 5. With WAIT_MAX=4 and mem_wait held -> after 4 stalled cycles phase=0, halted=1, timeout=1.
- exec held high through rst, rst released -> stays IDLE. rst asserted at phase 3 -> next cycle phase=0, retired=0.
- SINGLE_STEP_EN defined, step_mode=1: three exec pulses -> exactly three 5-phase bursts, retired=3, phase=0 between bursts.

Source files
------------

// File: rtl/phase_sequencer.sv
// ============================================================================
// phase_sequencer
// ----------------------------------------------------------------------------
// Multi-cycle phase generator for the processor core.  It produces the 3-bit
// phase bus consumed by the combinational control decoder.  It also handles
// the following:
//   - the run/stop key (exec), which is rising-edge detected,
//   - HLT detection,
//   - memory-wait stalls,
//   - a stall watchdog,
//   - a retired-instruction counter.
// All datapath enables stay in the decoder.  This block only sequences.
//
// Parameters:
//   PHASE_MAX  last phase of an instruction (4..7); phases run 1..PHASE_MAX
//   MEM_PHASE  second phase that honours mem_wait (2..PHASE_MAX)
//   WAIT_MAX   consecutive stalled cycles allowed before timeout (1..65535)
//   CNT_W      width of the retired-instruction counter
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   exec       in   run/stop key level (rising edge is the event)
//   hlt        in   current IR holds HLT
//   mem_wait   in   memory not ready; stalls phase 1 and MEM_PHASE
//   step_mode  in   (SINGLE_STEP_EN only) stop after every instruction
//   phase      out  current phase, 0 = not executing
//   running    out  high in any phase 1..PHASE_MAX
//   halted     out  high in HALT state
//   timeout    out  sticky watchdog expiry flag
//   p1_start   out  one-cycle pulse on entry to phase 1
//   retired    out  instructions completed, wraps silently
//
// Optional feature:
//   Define SINGLE_STEP_EN to add the step_mode input.  Without the macro the
//   port is absent and the block behaves as if step_mode were tied low.
//
// Every output comes straight from a flop or from a decode of the state
// register.  No input reaches an output without passing through a register.
// ============================================================================
module phase_sequencer #(
    parameter int PHASE_MAX = 5,
    parameter int MEM_PHASE = 4,
    parameter int WAIT_MAX  = 255,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec,
    input  logic             hlt,
    input  logic             mem_wait,
`ifdef SINGLE_STEP_EN
    input  logic             step_mode,
`endif
    output logic [2:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             timeout,
    output logic             p1_start,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [2:0]  PHASE_FIRST = 3'd1;
    localparam logic [2:0]  PHASE_HLT   = 3'd2;
    localparam logic [2:0]  PHASE_LAST  = 3'(PHASE_MAX);
    localparam logic [2:0]  PHASE_MEM   = 3'(MEM_PHASE);
    localparam logic [15:0] WAIT_LAST   = 16'(WAIT_MAX - 1);

    state_t             state_q, state_d;
    logic [2:0]         phase_q, phase_d;
    logic               timeout_q, timeout_d;
    logic               p1_q, p1_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               stop_q, stop_d;
    logic [15:0]        wait_q, wait_d;
    logic               exec_q;

    logic               exec_rise;
    logic               stall;
    logic               wd_expire;
    logic               step_active;

`ifdef SINGLE_STEP_EN
    assign step_active = step_mode;
`else
    assign step_active = 1'b0;
`endif

    // Only the press of the key counts, not how long it is held.
    assign exec_rise = exec & ~exec_q;

    // Memory waits matter only in the fetch phase and the data phase.
    assign stall = (state_q == RUN) & mem_wait &
                   ((phase_q == PHASE_FIRST) | (phase_q == PHASE_MEM));

    // wait_q counts the stalled cycles already seen.  Expiry fires on the
    // stalled cycle that would be number WAIT_MAX.
    assign wd_expire = stall & (wait_q == WAIT_LAST);

    // Next-state logic.  Every register holds by default.  p1_start is a
    // pulse, so it defaults low.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        timeout_d = timeout_q;
        p1_d      = 1'b0;
        retired_d = retired_q;
        stop_d    = stop_q;
        wait_d    = wait_q;

        case (state_q)
            IDLE: begin
                if (exec_rise) begin
                    state_d = RUN;
                    phase_d = PHASE_FIRST;
                    p1_d    = 1'b1;
                    stop_d  = 1'b0;
                    wait_d  = '0;
                end
            end

            RUN: begin
                if (wd_expire) begin
                    // A timeout beats a key press in the same cycle.  It
                    // does not count as a retired instruction.
                    state_d   = HALT;
                    phase_d   = '0;
                    timeout_d = 1'b1;
                    stop_d    = 1'b0;
                    wait_d    = '0;
                end else if (stall) begin
                    wait_d = wait_q + 16'd1;
                    // A press during a stall still asks for a stop at the
                    // end of the instruction.
                    if (exec_rise) begin
                        stop_d = 1'b1;
                    end
                end else begin
                    wait_d = '0;
                    if ((phase_q == PHASE_HLT) && hlt) begin
                        state_d   = HALT;
                        phase_d   = '0;
                        retired_d = retired_q + CNT_W'(1);
                        stop_d    = 1'b0;
                    end else if (phase_q == PHASE_LAST) begin
                        // A press that arrives on the final phase stops the
                        // core here.  It is not carried into the next
                        // instruction.
                        retired_d = retired_q + CNT_W'(1);
                        if (stop_q || exec_rise || step_active) begin
                            state_d = IDLE;
                            phase_d = '0;
                            stop_d  = 1'b0;
                        end else begin
                            phase_d = PHASE_FIRST;
                            p1_d    = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 3'd1;
                        if (exec_rise) begin
                            stop_d = 1'b1;
                        end
                    end
                end
            end

            HALT: begin
                if (exec_rise) begin
                    state_d   = RUN;
                    phase_d   = PHASE_FIRST;
                    timeout_d = 1'b0;
                    p1_d      = 1'b1;
                    stop_d    = 1'b0;
                    wait_d    = '0;
                end
            end

            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // State register.  exec_q also samples exec during reset.  A key held
    // through reset therefore shows no edge once reset drops.
    always_ff @(posedge clk) begin
        exec_q <= exec;
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            timeout_q <= 1'b0;
            p1_q      <= 1'b0;
            retired_q <= '0;
            stop_q    <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            timeout_q <= timeout_d;
            p1_q      <= p1_d;
            retired_q <= retired_d;
            stop_q    <= stop_d;
            wait_q    <= wait_d;
        end
    end

    assign phase    = phase_q;
    assign running  = (state_q == RUN);
    assign halted   = (state_q == HALT);
    assign timeout  = timeout_q;
    assign p1_start = p1_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// tb_phase_sequencer
// ----------------------------------------------------------------------------
// Scoreboard bench for phase_sequencer.  The DUT uses WAIT_MAX = 4 so that
// the watchdog can be reached in a few cycles.  The other parameters keep
// their default values.
//
// Each applyStimulus call does the following:
//   - drives one cycle of inputs on the falling edge,
//   - queues the outputs expected after the next rising edge.
//
// A separate monitor pops one entry shortly after every rising edge and
// compares it field by field.
// ============================================================================
module tb_phase_sequencer;

    typedef struct packed {
        logic [2:0]  phase;
        logic        running;
        logic        halted;
        logic        timeout;
        logic        p1_start;
        logic [15:0] retired;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exec = 1'b0;
    logic        hlt = 1'b0;
    logic        mem_wait = 1'b0;
    logic        step_mode = 1'b0;
    logic [2:0]  phase;
    logic        running;
    logic        halted;
    logic        timeout;
    logic        p1_start;
    logic [15:0] retired;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // 10-unit clock period.
    always #5 clk = ~clk;

    phase_sequencer #(
        .PHASE_MAX (5),
        .MEM_PHASE (4),
        .WAIT_MAX  (4),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .exec      (exec),
        .hlt       (hlt),
        .mem_wait  (mem_wait),
`ifdef SINGLE_STEP_EN
        .step_mode (step_mode),
`endif
        .phase     (phase),
        .running   (running),
        .halted    (halted),
        .timeout   (timeout),
        .p1_start  (p1_start),
        .retired   (retired)
    );

    // Compare one output field and record the result.
    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the
    // next rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic h,
                                 input logic m, input logic s,
                                 input logic [2:0] ph, input logic run,
                                 input logic hal, input logic to,
                                 input logic p1, input int ret);
        exp_t x;
        @(negedge clk);
        rst       = r;
        exec      = e;
        hlt       = h;
        mem_wait  = m;
        step_mode = s;
        x.phase    = ph;
        x.running  = run;
        x.halted   = hal;
        x.timeout  = to;
        x.p1_start = p1;
        x.retired  = 16'(ret);
        expq.push_back(x);
    endtask

    // Monitor: the DUT presents fresh outputs after every rising edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (expq.size() > 0) begin
            x = expq.pop_front();
            checkOutput("phase",    int'(phase),    int'(x.phase));
            checkOutput("running",  int'(running),  int'(x.running));
            checkOutput("halted",   int'(halted),   int'(x.halted));
            checkOutput("timeout",  int'(timeout),  int'(x.timeout));
            checkOutput("p1_start", int'(p1_start), int'(x.p1_start));
            checkOutput("retired",  int'(retired),  int'(x.retired));
        end
    end

    initial begin
        // Reset state.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Start the core, then run 15 cycles: phases 1..5 repeat, and
        // retired reaches 3.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, (k == 0), 0, 0, 0, 3'((k % 5) + 1), 1, 0, 0,
                          ((k % 5) == 0), k / 5);
        end

        // Press the key during phase 3.  The instruction finishes, then the
        // core goes idle.
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 3);
        applyStimulus(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 3);
        applyStimulus(0, 1, 0, 0, 0, 4, 1, 0, 0, 0, 3);
        applyStimulus(0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);

        // Restart, then hit HLT in phase 2.
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 4);
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 4);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5);

        // Leave HALT with a key press.
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 5);
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 5);

        // Three stalled cycles in phase 4, below the watchdog limit.
        applyStimulus(0, 0, 0, 1, 0, 4, 1, 0, 0, 0, 5);
        applyStimulus(0, 0, 0, 1, 0, 4, 1, 0, 0, 0, 5);
        applyStimulus(0, 0, 0, 1, 0, 4, 1, 0, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 6);

        // Stall in phase 1: p1_start must not pulse again.
        applyStimulus(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 6);
        applyStimulus(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 6);
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 6);
        applyStimulus(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 6);
        applyStimulus(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 6);

        // Watchdog: the 4th stalled cycle times out, even with a
        // simultaneous key press.
        applyStimulus(0, 0, 0, 1, 0, 4, 1, 0, 0, 0, 6);
        applyStimulus(0, 0, 0, 1, 0, 4, 1, 0, 0, 0, 6);
        applyStimulus(0, 0, 0, 1, 0, 4, 1, 0, 0, 0, 6);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 6);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6);

        // A key press clears halted and timeout.
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 6);
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 6);
        applyStimulus(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 6);

        // Reset in the middle of an instruction, then hold the key through
        // a second reset cycle.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // A genuine edge starts the core.  A press on phase 5 stops it right
        // after that instruction.
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

`ifdef SINGLE_STEP_EN
        // Single step: each key press runs exactly one instruction.
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 0, 1, b);
            for (int p = 2; p <= 5; p++) begin
                applyStimulus(0, 0, 0, 0, 1, 3'(p), 1, 0, 0, 0, b);
            end
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, b + 1);
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, b + 1);
        end
`endif

        // Let the monitor drain the scoreboard.
        @(posedge clk);
        #2;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
